// File: rtl/dac_spi_tx_pkg.sv
// Shared types and helpers for the DAC SPI transmitter and its tick generator.
package dac_spi_tx_pkg;

    localparam int unsigned FRAME_BITS = 32;
    localparam int unsigned BIT_CNT_W  = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_LOAD,
        ST_SHIFT,
        ST_GAP
    } state_t;

    // Bits needed to hold 0..n-1; never less than 1.
    function automatic int unsigned clogb2(input int unsigned n);
        int unsigned w;
        w = 1;
        for (int unsigned i = 1; i < 32; i++) begin
            if ((64'(1) << i) < 64'(n)) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/dac_spi_tx_tick.sv
// Free-running period counter; tick is high for one cycle every PERIOD clocks.
module tick_gen
    import dac_spi_tx_pkg::*;
#(
    parameter int unsigned PERIOD = 1000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int unsigned    CW   = clogb2(PERIOD);
    localparam logic [CW-1:0]  LAST = CW'(PERIOD - 1);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;

    always_comb begin
        cnt_nxt = (cnt == LAST) ? '0 : cnt + CW'(1);
    end

    // tick is registered against the upcoming count so it lines up with cnt == LAST.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            cnt  <= cnt_nxt;
            tick <= (cnt_nxt == LAST);
        end
    end

endmodule

// File: rtl/dac_spi_tx.sv
// Periodically fetches a sample from the source and writes it to an LTC2624-style DAC over SPI mode 0.
module dac_spi_tx
    import dac_spi_tx_pkg::*;
#(
    parameter int unsigned SIZE          = 12,
    parameter int unsigned DIV           = 4,
    parameter int unsigned SAMPLE_PERIOD = 1000,
    parameter logic [3:0]  CMD           = 4'b0011,
    parameter logic [3:0]  ADDR          = 4'b1111
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            enable,
    input  logic [SIZE-1:0] data,
    output logic            next,
    output logic            spi_sck,
    output logic            spi_mosi,
    output logic            dac_cs_n,
    output logic            busy,
    output logic            overrun
);

    localparam int unsigned             PH_W     = clogb2(DIV);
    localparam logic [PH_W-1:0]         PH_LAST  = PH_W'(DIV - 1);
    localparam logic [BIT_CNT_W-1:0]    BIT_LAST = BIT_CNT_W'(FRAME_BITS - 1);
    localparam int unsigned             PAD      = 16 - SIZE;

    logic                    tick;
    state_t                  state;
    logic [PH_W-1:0]         phase;
    logic [BIT_CNT_W-1:0]    bit_cnt;
    logic [FRAME_BITS-2:0]   shreg;
    logic [15:0]             sample_pad;
    logic [FRAME_BITS-1:0]   frame_word;

    tick_gen #(.PERIOD(SAMPLE_PERIOD)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // Sample is left-justified in a 16-bit field under the command and address nibbles.
    assign sample_pad = 16'(data) << PAD;
    assign frame_word = {8'h00, CMD, ADDR, sample_pad};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            next     <= 1'b0;
            spi_sck  <= 1'b0;
            spi_mosi <= 1'b0;
            dac_cs_n <= 1'b1;
            busy     <= 1'b0;
            overrun  <= 1'b0;
            phase    <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
        end else begin
            if (tick && (state != ST_IDLE)) begin
                overrun <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (tick && enable) begin
                        state <= ST_REQ;
                        next  <= 1'b1;
                        busy  <= 1'b1;
                    end
                end
                ST_REQ: begin
                    next  <= 1'b0;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    state <= ST_LOAD;
                end
                ST_LOAD: begin
                    shreg    <= frame_word[FRAME_BITS-2:0];
                    spi_mosi <= frame_word[FRAME_BITS-1];
                    dac_cs_n <= 1'b0;
                    spi_sck  <= 1'b0;
                    bit_cnt  <= '0;
                    phase    <= '0;
                    state    <= ST_SHIFT;
                end
                // Each bit: DIV cycles low then DIV high; the next bit moves onto mosi at the falling edge.
                ST_SHIFT: begin
                    if (phase == PH_LAST) begin
                        phase <= '0;
                        if (!spi_sck) begin
                            spi_sck <= 1'b1;
                        end else begin
                            spi_sck <= 1'b0;
                            if (bit_cnt == BIT_LAST) begin
                                spi_mosi <= 1'b0;
                                state    <= ST_GAP;
                            end else begin
                                bit_cnt  <= bit_cnt + BIT_CNT_W'(1);
                                spi_mosi <= shreg[FRAME_BITS-2];
                                shreg    <= {shreg[FRAME_BITS-3:0], 1'b0};
                            end
                        end
                    end else begin
                        phase <= phase + PH_W'(1);
                    end
                end
                ST_GAP: begin
                    dac_cs_n <= 1'b1;
                    if (phase == PH_LAST) begin
                        phase <= '0;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        phase <= phase + PH_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dac_spi_tx.sv
// Directed bench: one DUT at the nominal rate, one at an overrunning rate, both monitored on the SPI pins.
module tb_dac_spi_tx;

    localparam int LOG = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst    [2];
    logic        enable [2];
    logic [11:0] data   [2] = '{12'h000, 12'h000};
    logic        next_s [2];
    logic        sck    [2];
    logic        mosi   [2];
    logic        cs_n   [2];
    logic        busy   [2];
    logic        overrun[2];

    dac_spi_tx #(.SIZE(12), .DIV(4), .SAMPLE_PERIOD(1000), .CMD(4'b0011), .ADDR(4'b1111)) u_dut_a (
        .clk(clk), .rst(rst[0]), .enable(enable[0]), .data(data[0]), .next(next_s[0]),
        .spi_sck(sck[0]), .spi_mosi(mosi[0]), .dac_cs_n(cs_n[0]), .busy(busy[0]), .overrun(overrun[0])
    );

    dac_spi_tx #(.SIZE(12), .DIV(4), .SAMPLE_PERIOD(100), .CMD(4'b0011), .ADDR(4'b1111)) u_dut_b (
        .clk(clk), .rst(rst[1]), .enable(enable[1]), .data(data[1]), .next(next_s[1]),
        .spi_sck(sck[1]), .spi_mosi(mosi[1]), .dac_cs_n(cs_n[1]), .busy(busy[1]), .overrun(overrun[1])
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Sample source: answers each request with the next table entry.
    logic [11:0] src_tab[2][0:LOG-1];
    int          src_idx[2] = '{0, 0};
    always @(posedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (next_s[g]) begin
                data[g]    <= src_tab[g][src_idx[g] % LOG];
                src_idx[g] <= src_idx[g] + 1;
            end
        end
    end

    // Pin monitor: rebuilds frames from sck rising edges and logs request timing.
    logic [31:0] sh_m   [2] = '{32'h0, 32'h0};
    int          bits_m [2] = '{0, 0};
    int          low_m  [2] = '{0, 0};
    logic        in_frm [2] = '{1'b0, 1'b0};
    logic        p_sck  [2] = '{1'b0, 1'b0};
    logic        p_next [2] = '{1'b0, 1'b0};
    logic        p_busy [2] = '{1'b0, 1'b0};
    logic [31:0] frm_log [2][0:LOG-1];
    int          frm_bits[2][0:LOG-1];
    int          frm_low [2][0:LOG-1];
    int          frm_cnt [2] = '{0, 0};
    int          next_cyc[2][0:LOG-1];
    int          next_cnt[2] = '{0, 0};
    int          nwide   [2] = '{0, 0};
    int          nbusy   [2] = '{0, 0};

    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            p_sck[g]  <= sck[g];
            p_next[g] <= next_s[g];
            p_busy[g] <= busy[g];
            if (cs_n[g] === 1'b0) begin
                in_frm[g] <= 1'b1;
                low_m[g]  <= low_m[g] + 1;
                if (sck[g] && !p_sck[g]) begin
                    sh_m[g]   <= {sh_m[g][30:0], mosi[g]};
                    bits_m[g] <= bits_m[g] + 1;
                end
            end else if (in_frm[g]) begin
                if (frm_cnt[g] < LOG) begin
                    frm_log[g][frm_cnt[g]]  <= sh_m[g];
                    frm_bits[g][frm_cnt[g]] <= bits_m[g];
                    frm_low[g][frm_cnt[g]]  <= low_m[g];
                end
                frm_cnt[g] <= frm_cnt[g] + 1;
                in_frm[g]  <= 1'b0;
                low_m[g]   <= 0;
                bits_m[g]  <= 0;
                sh_m[g]    <= 32'h0;
            end
            if (next_s[g]) begin
                if (p_next[g]) begin
                    nwide[g] <= nwide[g] + 1;
                end else begin
                    if (next_cnt[g] < LOG) next_cyc[g][next_cnt[g]] <= cyc;
                    next_cnt[g] <= next_cnt[g] + 1;
                    if (p_busy[g]) nbusy[g] <= nbusy[g] + 1;
                end
            end
        end
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic run_to(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    logic [31:0] exp_stream[6] = '{32'h003F0010, 32'h003F0020, 32'h003F0030,
                                   32'h003F0010, 32'h003F0020, 32'h003F0030};
    logic [31:0] exp_b[4]      = '{32'h003F0050, 32'h003F02A0, 32'h003F04F0, 32'h003F0740};

    initial begin
        int r;
        int r2;
        int n;
        for (int k = 0; k < LOG; k++) begin
            src_tab[0][k] = 12'h000;
            src_tab[1][k] = 12'(k * 37 + 5);
        end
        src_tab[0][0] = 12'hABC;
        src_tab[0][1] = 12'h001; src_tab[0][2] = 12'h002; src_tab[0][3] = 12'h003;
        src_tab[0][4] = 12'h001; src_tab[0][5] = 12'h002; src_tab[0][6] = 12'h003;
        src_tab[0][7] = 12'h5A5;
        src_tab[0][8] = 12'h123;
        src_tab[0][9] = 12'h9E7;

        rst[0] = 1'b1; rst[1] = 1'b1;
        enable[0] = 1'b1; enable[1] = 1'b1;
        repeat (5) @(negedge clk);
        chk("rst_outs_a", 32'({next_s[0], sck[0], mosi[0], cs_n[0], busy[0], overrun[0]}), 32'b000100);
        chk("rst_outs_b", 32'({next_s[1], sck[1], mosi[1], cs_n[1], busy[1], overrun[1]}), 32'b000100);
        rst[0] = 1'b0; rst[1] = 1'b0;
        r = cyc;
        @(negedge clk);
        chk("post_rel_a", 32'({next_s[0], sck[0], mosi[0], cs_n[0], busy[0], overrun[0]}), 32'b000100);

        // Fast-rate instance: second tick lands mid-frame.
        run_to(r + 100);
        chk("b_first_next", 32'(next_s[1]), 32'd1);
        run_to(r + 150);
        chk("b_ovr_before", 32'(overrun[1]), 32'd0);
        run_to(r + 205);
        chk("b_ovr_after", 32'(overrun[1]), 32'd1);
        chk("b_busy_mid", 32'(busy[1]), 32'd1);
        run_to(r + 400);
        chk("b_second_next", 32'(next_s[1]), 32'd1);

        // Nominal instance: first request exactly one period after release.
        run_to(r + 999);
        chk("a_pre_next", 32'(next_s[0]), 32'd0);
        run_to(r + 1000);
        n = cyc;
        chk("a_first_next", 32'(next_s[0]), 32'd1);
        chk("a_busy_req", 32'(busy[0]), 32'd1);
        run_to(n + 1);
        chk("a_next_width", 32'(next_s[0]), 32'd0);
        run_to(n + 262);
        chk("a_busy_last", 32'(busy[0]), 32'd1);
        run_to(n + 263);
        chk("a_busy_end", 32'(busy[0]), 32'd0);
        chk("a_csn_end", 32'(cs_n[0]), 32'd1);
        run_to(n + 270);
        chk("a_frm_cnt1", 32'(frm_cnt[0]), 32'd1);
        chk("a_frm0", frm_log[0][0], 32'h003FABC0);
        chk("a_frm0_bits", 32'(frm_bits[0][0]), 32'd32);
        chk("a_frm0_csn_low", 32'(frm_low[0][0]), 32'd257);

        // Stream of six frames.
        run_to(r + 7300);
        for (int k = 1; k <= 6; k++) begin
            chk($sformatf("a_stream%0d", k), frm_log[0][k], exp_stream[k-1]);
            chk($sformatf("a_space%0d", k), 32'(next_cyc[0][k] - next_cyc[0][k-1]), 32'd1000);
        end
        chk("a_next_cnt7", 32'(next_cnt[0]), 32'd7);
        chk("a_nwide", 32'(nwide[0]), 32'd0);

        // Disabled for three tick periods.
        run_to(r + 7500);
        enable[0] = 1'b0;
        run_to(r + 10500);
        chk("a_dis_next_cnt", 32'(next_cnt[0]), 32'd7);
        chk("a_dis_frm_cnt", 32'(frm_cnt[0]), 32'd7);
        chk("a_dis_csn", 32'(cs_n[0]), 32'd1);
        chk("a_dis_ovr", 32'(overrun[0]), 32'd0);
        enable[0] = 1'b1;
        run_to(r + 11000);
        chk("a_resume_next", 32'(next_s[0]), 32'd1);
        run_to(r + 11300);
        chk("a_resume_frm", frm_log[0][7], 32'h003F5A50);
        chk("a_resume_cyc", 32'(next_cyc[0][7] - r), 32'd11000);

        // Reset in the middle of bit 10.
        run_to(r + 12000);
        chk("a_f8_next", 32'(next_s[0]), 32'd1);
        run_to(r + 12085);
        chk("a_f8_bits", 32'(bits_m[0]), 32'd10);
        chk("a_f8_csn", 32'(cs_n[0]), 32'd0);
        rst[0] = 1'b1;
        #1;
        chk("a_rst_mid", 32'({cs_n[0], sck[0], busy[0]}), 32'b100);
        repeat (3) @(negedge clk);
        rst[0] = 1'b0;
        r2 = cyc;
        run_to(r2 + 999);
        chk("a_rst_pre_next", 32'(next_s[0]), 32'd0);
        run_to(r2 + 1000);
        chk("a_rst_next", 32'(next_s[0]), 32'd1);
        run_to(r2 + 1300);
        chk("a_frm_cnt10", 32'(frm_cnt[0]), 32'd10);
        chk("a_trunc_bits", 32'(frm_bits[0][8]), 32'd10);
        chk("a_trunc_val", frm_log[0][8], 32'h0);
        chk("a_post_rst_frm", frm_log[0][9], 32'h003F9E70);
        chk("a_post_rst_bits", 32'(frm_bits[0][9]), 32'd32);
        chk("a_post_rst_low", 32'(frm_low[0][9]), 32'd257);
        chk("a_nbusy", 32'(nbusy[0]), 32'd0);

        // Fast-rate instance: frames stay intact despite dropped ticks.
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("b_frm%0d", k), frm_log[1][k], exp_b[k]);
            chk($sformatf("b_bits%0d", k), 32'(frm_bits[1][k]), 32'd32);
        end
        chk("b_space", 32'(next_cyc[1][1] - next_cyc[1][0]), 32'd300);
        chk("b_nbusy", 32'(nbusy[1]), 32'd0);
        chk("b_nwide", 32'(nwide[1]), 32'd0);
        chk("b_ovr_sticky", 32'(overrun[1]), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
